// File: rtl/ox_pkg.sv
// Shared definitions for the keypad front end of the O/X MLP classifier.
// Contents:
//   KEY_* : key indices on the 12-bit scanner bus (bits 0-8 are keys 1-9)
//   GRID_N : number of pixels in the 3x3 drawing grid
//   deb_state_e : debounce FSM states
//   is_onehot / onehot_to_idx : scanner code helpers
package ox_pkg;

  localparam int KEY_N    = 12;
  localparam int KEY_STAR = 9;
  localparam int KEY_ZERO = 10;
  localparam int KEY_HASH = 11;
  localparam int GRID_N   = 9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CAND = 2'd1,
    HELD = 2'd2
  } deb_state_e;

  function automatic logic is_onehot(input logic [KEY_N-1:0] code);
    return (code != '0) && ((code & (code - KEY_N'(1))) == '0);
  endfunction

  // Only meaningful for a one-hot code; for anything else it returns the
  // highest set bit (or 0).
  function automatic logic [3:0] onehot_to_idx(input logic [KEY_N-1:0] code);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < KEY_N; i++) begin
      if (code[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Synchronises the scanner's code/valid pair, turns each valid rise into a
// single hit, rejects malformed codes and debounces presses.
// Ports:
//   clk, rst        : system clock, synchronous active-high reset
//   key_onehot[11:0]: scanner code (asynchronous to this logic's view)
//   key_valid       : scanner valid level, one pulse per scan while held
//   press           : combinational, high in the cycle the FSM enters HELD;
//                     the parent registers its action on the same edge
//   press_idx[3:0]  : index of the key being accepted (valid with press)
//   state           : current debounce state, for observation
module keypad_debounce
  import ox_pkg::*;
#(
  parameter int DEBOUNCE_HITS = 3,
  parameter int RELEASE_CYC   = 20000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [KEY_N-1:0] key_onehot,
  input  logic             key_valid,
  output logic             press,
  output logic [3:0]       press_idx,
  output deb_state_e       state
);

  localparam int SIL_W = $clog2(RELEASE_CYC + 1);
  localparam int HIT_W = (DEBOUNCE_HITS < 2) ? 1 : $clog2(DEBOUNCE_HITS + 1);
  localparam logic [SIL_W-1:0] SIL_MAX  = SIL_W'(RELEASE_CYC);
  localparam logic [HIT_W-1:0] HITS_MAX = HIT_W'(DEBOUNCE_HITS);

  logic             sync1_valid, sync2_valid, dly_valid;
  logic [KEY_N-1:0] sync1_code, sync2_code;

  deb_state_e       state_q, state_d;
  logic [KEY_N-1:0] code_q, code_d;
  logic [HIT_W-1:0] hits_q, hits_d, hits_inc;
  logic [SIL_W-1:0] sil_q, sil_d;

  logic hit, hit_ok;

  // The scanner holds its code across the valid pulse, so sampling the
  // synchronised bus in the rise cycle gives a settled code.
  assign hit      = sync2_valid & ~dly_valid;
  assign hit_ok   = hit & is_onehot(sync2_code);
  assign hits_inc = hits_q + HIT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_valid <= 1'b0;
      sync2_valid <= 1'b0;
      dly_valid   <= 1'b0;
      sync1_code  <= '0;
      sync2_code  <= '0;
      state_q     <= IDLE;
      code_q      <= '0;
      hits_q      <= '0;
      sil_q       <= '0;
    end else begin
      sync1_valid <= key_valid;
      sync2_valid <= sync1_valid;
      dly_valid   <= sync2_valid;
      sync1_code  <= key_onehot;
      sync2_code  <= sync1_code;
      state_q     <= state_d;
      code_q      <= code_d;
      hits_q      <= hits_d;
      sil_q       <= sil_d;
    end
  end

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    hits_d  = hits_q;
    press   = 1'b0;
    // Silence counter saturates so a long idle period cannot wrap it.
    sil_d   = (sil_q == SIL_MAX) ? sil_q : sil_q + SIL_W'(1);
    if (hit_ok) sil_d = '0;

    unique case (state_q)
      IDLE: begin
        if (hit_ok) begin
          code_d = sync2_code;
          hits_d = HIT_W'(1);
          if (DEBOUNCE_HITS <= 1) begin
            state_d = HELD;
            press   = 1'b1;
          end else begin
            state_d = CAND;
          end
        end
      end
      CAND: begin
        if (hit_ok) begin
          if (sync2_code == code_q) begin
            hits_d = hits_inc;
            if (hits_inc == HITS_MAX) begin
              state_d = HELD;
              press   = 1'b1;
            end
          end else begin
            // A different key restarts the count on the new code.
            code_d = sync2_code;
            hits_d = HIT_W'(1);
          end
        end else if (sil_q == SIL_MAX) begin
          state_d = IDLE;
        end
      end
      HELD: begin
        // Any valid hit keeps the key held (sil_d cleared above); no repeats.
        if (!hit_ok && sil_q == SIL_MAX) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign press_idx = onehot_to_idx(code_d);
  assign state     = state_q;

endmodule

// File: rtl/keypad_grid_capture.sv
// Turns debounced keypad presses into a 3x3 binary drawing grid and submits
// snapshots of it to the MLP input stage.
// Ports:
//   clk, rst         : system clock, synchronous active-high reset
//   key_onehot[11:0] : scanner code (bits 0-8 keys 1-9, 9 '*', 10 '0', 11 '#')
//   key_valid        : scanner valid level
//   grid[8:0]        : live pixel grid, bit n is key n+1, row-major
//   key_event        : one-cycle pulse per accepted press
//   key_code[3:0]    : index of the last accepted key
//   frame_valid      : submitted frame pending
//   frame_data[8:0]  : grid snapshot, stable while frame_valid is high
//   frame_ready      : downstream accepts the frame
//   debug_state      : debounce FSM state, for observation
// Frame handshake: a transfer completes on any edge where frame_valid and
// frame_ready are both high; frame_valid then drops and frame_data may change
// only while frame_valid is low. frame_ready with no frame pending is ignored.
module keypad_grid_capture
  import ox_pkg::*;
#(
  parameter int DEBOUNCE_HITS = 3,
  parameter int RELEASE_CYC   = 20000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [KEY_N-1:0]  key_onehot,
  input  logic              key_valid,
  output logic [GRID_N-1:0] grid,
  output logic              key_event,
  output logic [3:0]        key_code,
  output logic              frame_valid,
  output logic [GRID_N-1:0] frame_data,
  input  logic              frame_ready,
  output deb_state_e        debug_state
);

  logic              press;
  logic [3:0]        press_idx;
  logic [GRID_N-1:0] toggle_mask;

  keypad_debounce #(
    .DEBOUNCE_HITS(DEBOUNCE_HITS),
    .RELEASE_CYC  (RELEASE_CYC)
  ) u_debounce (
    .clk       (clk),
    .rst       (rst),
    .key_onehot(key_onehot),
    .key_valid (key_valid),
    .press     (press),
    .press_idx (press_idx),
    .state     (debug_state)
  );

  // Zero for '*', '0' and '#', so XORing it leaves the grid alone.
  always_comb begin
    toggle_mask = '0;
    if (press_idx < 4'(GRID_N)) toggle_mask[press_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grid        <= '0;
      key_event   <= 1'b0;
      key_code    <= '0;
      frame_valid <= 1'b0;
      frame_data  <= '0;
    end else begin
      key_event <= press;
      if (press) begin
        key_code <= press_idx;
        if (press_idx == 4'(KEY_STAR)) grid <= '0;
        else                           grid <= grid ^ toggle_mask;
      end
      // A completing handshake wins over a '#' in the same cycle.
      if (frame_valid && frame_ready) begin
        frame_valid <= 1'b0;
      end else if (press && press_idx == 4'(KEY_HASH) && !frame_valid) begin
        frame_valid <= 1'b1;
        frame_data  <= grid;
      end
    end
  end

endmodule

// File: tb/tb_keypad_grid_capture.sv
module tb_keypad_grid_capture;
  import ox_pkg::*;

  localparam int DEB = 3;
  localparam int REL = 200;
  localparam int GAP = 12;
  localparam int W   = 23;   // {key_code, grid, frame_valid, frame_data}

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] key_onehot;
  logic        key_valid;
  logic        frame_ready;
  logic [8:0]  grid, frame_data;
  logic        key_event, frame_valid;
  logic [3:0]  key_code;
  deb_state_e  debug_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  keypad_grid_capture #(.DEBOUNCE_HITS(DEB), .RELEASE_CYC(REL)) dut (
    .clk        (clk),
    .rst        (rst),
    .key_onehot (key_onehot),
    .key_valid  (key_valid),
    .grid       (grid),
    .key_event  (key_event),
    .key_code   (key_code),
    .frame_valid(frame_valid),
    .frame_data (frame_data),
    .frame_ready(frame_ready),
    .debug_state(debug_state)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int           lat_q[$];
  int           vectors = 0;
  int           miscompares = 0;
  logic [8:0]   m_grid, m_fd;
  logic         m_fv;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Event monitor: every key_event must match the head of the queue in
  // content and in arrival cycle.
  always @(negedge clk) begin
    if (rst === 1'b0 && key_event === 1'b1) begin
      check("event_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        check("event_state", {key_code, grid, frame_valid, frame_data}, exp_q.pop_front());
        check("event_latency", cyc, lat_q.pop_front());
      end
    end
  end

  // Reference model of the action taken when a press is accepted.
  task automatic push_expect(input int idx, input bit rdy, input int when);
    if (idx < GRID_N) m_grid[idx] = ~m_grid[idx];
    else if (idx == KEY_STAR) m_grid = '0;
    if (m_fv && rdy) m_fv = 1'b0;
    else if (idx == KEY_HASH && !m_fv) begin
      m_fv = 1'b1;
      m_fd = m_grid;
    end
    exp_q.push_back({4'(idx), m_grid, m_fv, m_fd});
    lat_q.push_back(when);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One scanner pulse. On the final debounce hit the expected event is
  // queued; its key_event is due in the posedge three after this launch.
  task automatic hit(input logic [11:0] code, input bit last, input int idx, input bit rdy);
    key_onehot = code;
    key_valid  = 1'b1;
    if (last) push_expect(idx, rdy, cyc + 3);
    tick(2);
    key_valid = 1'b0;
    if (rdy) begin
      frame_ready = 1'b1;   // lands on the action edge
      tick(1);
      frame_ready = 1'b0;
      tick(GAP - 1);
    end else begin
      tick(GAP);
    end
  endtask

  task automatic press(input int idx, input bit rdy);
    logic [11:0] c;
    c = 12'd1 << idx;
    for (int i = 0; i < DEB; i++) hit(c, i == DEB - 1, idx, rdy && (i == DEB - 1));
    check("drain", exp_q.size(), 0);
    exp_q.delete();
    lat_q.delete();
  endtask

  task automatic release_key();
    key_onehot = '0;
    tick(REL + 20);
  endtask

  task automatic tap(input int idx);
    press(idx, 1'b0);
    release_key();
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [11:0] bad;
    rst = 1'b1; key_valid = 1'b0; key_onehot = '0; frame_ready = 1'b0;
    m_grid = '0; m_fd = '0; m_fv = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(1);
    check("rst_grid", grid, 0);
    check("rst_key_event", key_event, 0);
    check("rst_key_code", key_code, 0);
    check("rst_frame_valid", frame_valid, 0);
    check("rst_frame_data", frame_data, 0);
    check("rst_state", debug_state, IDLE);

    // Key 5, then held for 10 more scans with no repeat event.
    press(4, 1'b0);
    check("k5_grid", grid, 9'b000010000);
    check("k5_code", key_code, 4);
    check("k5_state", debug_state, HELD);
    for (int i = 0; i < 10; i++) hit(12'd1 << 4, 1'b0, 4, 1'b0);
    check("k5_hold_grid", grid, 9'b000010000);
    release_key();
    check("k5_released", debug_state, IDLE);

    tap(KEY_STAR);
    check("star_grid", grid, 0);

    // Draw the diagonal and submit with no ready.
    tap(0); tap(4); tap(8);
    check("diag_grid", grid, 9'b100010001);
    tap(KEY_HASH);
    check("hash_fv", frame_valid, 1);
    check("hash_fd", frame_data, 9'b100010001);
    tap(0);
    check("edit_grid", grid, 9'b100010000);
    check("edit_fd_kept", frame_data, 9'b100010001);

    // One-cycle ready pulse completes the handshake.
    frame_ready = 1'b1; tick(1); frame_ready = 1'b0; m_fv = 1'b0;
    check("ready_fv_drop", frame_valid, 0);
    frame_ready = 1'b1; tick(2); frame_ready = 1'b0;
    check("ready_idle_ignored", frame_valid, 0);
    tap(KEY_HASH);
    check("hash2_fv", frame_valid, 1);
    check("hash2_fd", frame_data, 9'b100010000);

    // '#' and ready on the same edge: handshake wins, frame drops.
    press(KEY_HASH, 1'b1);
    release_key();
    check("hash_ready_fv", frame_valid, 0);

    // Candidate restart: two hits of key 2, then key 3 takes over.
    hit(12'd1 << 1, 1'b0, 1, 1'b0);
    hit(12'd1 << 1, 1'b0, 1, 1'b0);
    hit(12'd1 << 2, 1'b0, 2, 1'b0);
    check("restart_state", debug_state, CAND);
    check("restart_no_code", key_code, KEY_HASH);
    hit(12'd1 << 2, 1'b0, 2, 1'b0);
    hit(12'd1 << 2, 1'b1, 2, 1'b0);
    release_key();
    check("restart_code", key_code, 2);
    check("restart_grid", grid, 9'b100010100);

    // Malformed code from IDLE and inside CAND.
    bad = 12'b000000000110;
    hit(bad, 1'b0, 0, 1'b0);
    check("bad_idle_state", debug_state, IDLE);
    check("bad_idle_grid", grid, 9'b100010100);
    hit(12'd1 << 3, 1'b0, 3, 1'b0);
    hit(bad, 1'b0, 0, 1'b0);
    check("bad_cand_state", debug_state, CAND);
    release_key();
    check("cand_timeout_state", debug_state, IDLE);
    check("cand_timeout_grid", grid, 9'b100010100);

    // Key 7 to HELD, frame pending, then '*' and ignored '#'.
    press(6, 1'b0);
    check("k7_state", debug_state, HELD);
    release_key();
    tap(KEY_HASH);
    check("k7_fd", frame_data, 9'b101010100);
    tap(KEY_STAR);
    check("star_pend_grid", grid, 0);
    check("star_pend_fv", frame_valid, 1);
    check("star_pend_fd", frame_data, 9'b101010100);
    tap(KEY_HASH);
    check("hash_pend_fd", frame_data, 9'b101010100);
    tap(KEY_ZERO);
    check("zero_code", key_code, KEY_ZERO);
    check("zero_grid", grid, 0);

    // Reset mid-CAND with a frame pending.
    hit(12'd1 << 0, 1'b0, 0, 1'b0);
    check("pre_rst_state", debug_state, CAND);
    rst = 1'b1;
    tick(1);
    check("mid_rst_state", debug_state, IDLE);
    check("mid_rst_fv", frame_valid, 0);
    check("mid_rst_fd", frame_data, 0);
    check("mid_rst_code", key_code, 0);
    check("mid_rst_event", key_event, 0);
    rst = 1'b0;
    m_grid = '0; m_fd = '0; m_fv = 1'b0;
    tick(GAP);
    check("final_drain", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
